// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: per-axis timing sets for the standard modes,
// sync polarity constants and the helper that sums an axis into its total.
package vga_pkg;

    // One axis (horizontal in pixels or vertical in lines) of a video mode.
    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
    } axis_timing_t;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // 640x480@60: both syncs active low.
    localparam axis_timing_t H_640X480  = '{visible: 640,  front: 16, sync: 96,  back: 48};
    localparam axis_timing_t V_640X480  = '{visible: 480,  front: 10, sync: 2,   back: 33};
    // 800x600@60: both syncs active high.
    localparam axis_timing_t H_800X600  = '{visible: 800,  front: 40, sync: 128, back: 88};
    localparam axis_timing_t V_800X600  = '{visible: 600,  front: 1,  sync: 4,   back: 23};
    // 1024x768@60: both syncs active low.
    localparam axis_timing_t H_1024X768 = '{visible: 1024, front: 24, sync: 136, back: 160};
    localparam axis_timing_t V_1024X768 = '{visible: 768,  front: 3,  sync: 6,   back: 29};

    // Full period of one axis: visible + front porch + sync + back porch.
    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with decoded wrap, visible and
// sync flags. Used once for pixels within a line and once for lines in a frame.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE  = 640,
    parameter int unsigned FRONT    = 16,
    parameter int unsigned SYNC     = 96,
    parameter int unsigned BACK     = 48,
    parameter logic        SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             visible,
    output logic             sync
);

    localparam int unsigned TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

    // Decode bounds one bit wider than the count so a total of exactly
    // 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0] LAST       = (CNT_W+1)'(TOTAL - 1);
    localparam logic [CNT_W:0] VIS_END    = (CNT_W+1)'(VISIBLE);
    localparam logic [CNT_W:0] SYNC_FIRST = (CNT_W+1)'(VISIBLE + FRONT);
    localparam logic [CNT_W:0] SYNC_LAST  = (CNT_W+1)'(VISIBLE + FRONT + SYNC - 1);

    logic [CNT_W:0] cnt_ext;

    assign cnt_ext = {1'b0, count};

    // Position register: restart on clr, otherwise advance on step and wrap at the end.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for all clocked state, so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    // Decode the current position into wrap, visible-area and sync flags.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        wrap    = 1'b0;
        visible = 1'b0;
        sync    = ~SYNC_POL;
        if (cnt_ext == LAST) begin
            wrap = 1'b1;
        end
        if (cnt_ext < VIS_END) begin
            visible = 1'b1;
        end
        if ((cnt_ext >= SYNC_FIRST) && (cnt_ext <= SYNC_LAST)) begin
            sync = SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock divider, horizontal and
// vertical axis counters, frame counter and a registered, mutually aligned
// output stage that idles while en is low.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = H_640X480.visible,
    parameter int unsigned H_FRONT    = H_640X480.front,
    parameter int unsigned H_SYNC     = H_640X480.sync,
    parameter int unsigned H_BACK     = H_640X480.back,
    parameter int unsigned V_VISIBLE  = V_640X480.visible,
    parameter int unsigned V_FRONT    = V_640X480.front,
    parameter int unsigned V_SYNC     = V_640X480.sync,
    parameter int unsigned V_BACK     = V_640X480.back,
    parameter logic        H_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic        V_SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned FCNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              pix_tick,
    output logic              hsync,
    output logic              vsync,
    output logic              display,
    output logic [CNT_W-1:0]  pixel_x,
    output logic [CNT_W-1:0]  pixel_y,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL   = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL   = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if ((64'd1 << CNT_W) < 64'(MAX_TOTAL)) begin : g_cnt_w_check
        $error("vga_timing_gen: CNT_W too narrow for the line/frame total");
    end
    if (CLK_DIV < 1) begin : g_clk_div_check
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic              period_first;
    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              h_wrap, h_vis, h_sync;
    logic              v_wrap, v_vis, v_sync;
    logic              frame_wrap;
    logic [FCNT_W-1:0] frame_acc;

    assign tick         = (div_cnt == DIV_LAST);
    assign period_first = (div_cnt == '0);
    assign frame_wrap   = en && tick && h_wrap && v_wrap;

    // Pixel-clock divider: counts clk cycles within one pixel period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .VISIBLE  (H_VISIBLE),
        .FRONT    (H_FRONT),
        .SYNC     (H_SYNC),
        .BACK     (H_BACK),
        .SYNC_POL (H_SYNC_POL),
        .CNT_W    (CNT_W)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .clr     (!en),
        .step    (en && tick),
        .count   (h_cnt),
        .wrap    (h_wrap),
        .visible (h_vis),
        .sync    (h_sync)
    );

    vga_axis_counter #(
        .VISIBLE  (V_VISIBLE),
        .FRONT    (V_FRONT),
        .SYNC     (V_SYNC),
        .BACK     (V_BACK),
        .SYNC_POL (V_SYNC_POL),
        .CNT_W    (CNT_W)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .clr     (!en),
        .step    (en && tick && h_wrap),
        .count   (v_cnt),
        .wrap    (v_wrap),
        .visible (v_vis),
        .sync    (v_sync)
    );

    // Completed-frame counter: bumps on the last clk of the last pixel of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_acc <= '0;
        end else if (frame_wrap) begin
            frame_acc <= frame_acc + 1'b1;
        end
    end

    // Output stage: one-clk-late snapshot of the timing state, idle while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_tick    <= 1'b0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display     <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            // Registered from frame_acc so the new count appears with frame_start.
            frame_cnt <= frame_acc;
            if (en) begin
                pix_tick    <= period_first;
                hsync       <= h_sync;
                vsync       <= v_sync;
                display     <= h_vis && v_vis;
                pixel_x     <= h_cnt;
                pixel_y     <= v_cnt;
                line_start  <= period_first && (h_cnt == '0);
                frame_start <= period_first && (h_cnt == '0) && (v_cnt == '0);
            end else begin
                pix_tick    <= 1'b0;
                hsync       <= ~H_SYNC_POL;
                vsync       <= ~V_SYNC_POL;
                display     <= 1'b0;
                pixel_x     <= '0;
                pixel_y     <= '0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync generator. Adds per-axis timing parameters, selectable sync polarity, an internal pixel-clock divider (pixel enable), a run/hold enable, registered line/frame strobes and a frame counter. Sits between the system clock domain and the pixel/colour pipeline; downstream logic consumes pix_tick, display and pixel_x/pixel_y.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active low, 1 = active high)
V_SYNC_POL, 0, vsync active level
CLK_DIV, 1, clk cycles per pixel (>=1)
CNT_W, 10, counter/coordinate width
FCNT_W, 8, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  1 = run timing; 0 = hold at frame origin, outputs idle
pix_tick  out  1  one-clk strobe on first clk of each pixel period
hsync  out  1  horizontal sync, polarity per H_SYNC_POL
vsync  out  1  vertical sync, polarity per V_SYNC_POL
display  out  1  1 inside visible area
pixel_x  out  CNT_W  current horizontal count (raw, 0..H_TOTAL-1)
pixel_y  out  CNT_W  current vertical count (raw, 0..V_TOTAL-1)
line_start  out  1  one-clk strobe when pixel_x becomes 0
frame_start  out  1  one-clk strobe when pixel_x=0 and pixel_y=0
frame_cnt  out  FCNT_W  completed-frame counter, wraps

Behaviour:
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Elaboration error if 2^CNT_W < max(H_TOTAL, V_TOTAL) or CLK_DIV < 1.
- Internal state: divider d (0..CLK_DIV-1), h (0..H_TOTAL-1), v (0..V_TOTAL-1). tick = (d == CLK_DIV-1).
- en=1: d increments each clk, wraps to 0 on tick. On tick: h increments; at H_TOTAL-1 it wraps to 0 and v increments; v wraps at V_TOTAL-1. Frame wrap (tick, h=H_TOTAL-1, v=V_TOTAL-1) increments frame_cnt modulo 2^FCNT_W.
- en=0: d, h, v synchronously forced to 0; frame_cnt holds.
- Output stage, registered, captured every clk from the current d/h/v (1-clk latency, all outputs mutually aligned):
  pixel_x<=h, pixel_y<=v; display<=(h<H_VISIBLE)&&(v<V_VISIBLE);
  hsync<=H_SYNC_POL when h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], else ~H_SYNC_POL; vsync likewise with V_* over v;
  pix_tick<=(d==0); line_start<=(d==0)&&(h==0); frame_start<=line_start term && (v==0).
- With CLK_DIV>1, coordinates/sync/display hold for CLK_DIV clks; strobes fire only on the first clk of the period.
- When en=0 the output stage drives idle: hsync/vsync inactive, display/strobes 0, pixel_x/pixel_y 0.
- First clk edge with en=1 after reset or after en low: outputs show (0,0) with pix_tick, line_start and frame_start all 1.
- Reset (async, any time incl. mid-frame): d=h=v=0, frame_cnt=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, display=0, pixel_x=pixel_y=0, all strobes 0.
- en dropping mid-frame: state restarts from origin; no partial-frame frame_cnt increment.

Decomposition:
- Package vga_pkg: timing constant sets for standard modes (640x480@60, 800x600@60, 1024x768@60), sync polarity constants, function computing total from visible/porch/sync.
- Sub-module vga_axis_counter (count, wrap flag, visible flag, sync decode), instantiated for h and v; the divider and output register stage stay in vga_timing_gen.

Test Plan:
- Defaults, CLK_DIV=1, en=1 after reset -> frame_start at first clk; hsync low for exactly 96 clks starting at pixel_x=656; line period 800 clks; frame period 420000 clks; display high 640 clks per visible line.
- CLK_DIV=4 -> pix_tick every 4th clk; pixel_x steps every 4 clks; line period 3200 clks; line_start high 1 clk per line.
- 800x600 params (40/128/88, 1/4/23), both polarities=1 -> hsync high for 128 pixels at pixel_x 840..967; vsync high for lines 601..604; H_TOTAL=1056, V_TOTAL=628.
- Tiny timings (H 4/1/1/1, V 2/1/1/1), FCNT_W=2 -> frame_cnt 0,1,2,3,0 across five frames of 35 clks each.
- en low at pixel_x=300, pixel_y=100 for 10 clks -> outputs idle during low; first clk after en high shows (0,0) with frame_start=1; frame_cnt unchanged.
- Async rst pulse mid-line (between clock edges) -> all outputs at reset values immediately; after release, frame_start on first edge.
